add_sub_serial: RTL and testbench
=================================

Name: add_sub_serial

Overview:
- Parametrised, multi-cycle add/subtract unit with a start/busy/done handshake.
- Processes operands DIGIT bits per clock, least significant slice first.
- Reports carry/borrow, signed overflow and zero flags.
- Optional accumulate mode chains the previous result in as operand A, so the block serves as a running-total datapath for lab top-levels driven from switches and keys.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- DIGIT, 1, bits processed per cycle; WIDTH must be an integer multiple of DIGIT; a non-multiple is a compile-time error.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op_sub  input  1  0 = A+B, 1 = A-B.
- op_acc  input  1  1 = operand A is the current result register, not input a.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result and flags are updated.
- result  output  WIDTH  registered result; held until the next completion.
- carry_out  output  1  add: carry out of the MSB; sub: borrow (1 when A<B unsigned).
- overflow  output  1  signed two's-complement overflow of the operation.
- zero  output  1  result == 0.

Behaviour:
- Reset
  - rst_n low at a rising edge forces IDLE.
  - Outputs after reset: busy=0, done=0, result=0, carry_out=0, overflow=0, zero=1.
  - Internal operand shifters and slice counter are cleared.
  - Reset mid-operation aborts; no done pulse is issued.
- FSM states: IDLE, BUSY, DONE.
- IDLE
  - start=1 at an edge latches A (a, or result if op_acc=1), B, op_sub.
  - Clears the slice counter; the internal carry is loaded with op_sub.
  - Transitions to BUSY.
  - start=0: stay in IDLE.
- BUSY
  - Each edge computes one DIGIT-bit slice as A_slice + (op_sub ? ~B_slice : B_slice) + carry, stores the slice, and propagates the carry.
  - After WIDTH/DIGIT edges, transitions to DONE.
  - start is ignored in BUSY; a, b, op_sub and op_acc changes have no effect after latch.
- DONE (one cycle)
  - done=1, busy=0.
  - result, carry_out, overflow and zero are all updated at the edge entering DONE.
  - The next edge returns to IDLE; start is not accepted in DONE.
- Timing
  - busy=1 exactly in the cycles while in BUSY.
  - Latency from the start-sampling edge to done high is WIDTH/DIGIT+1 edges.
  - Minimum start-to-start spacing is WIDTH/DIGIT+2 cycles.
- Arithmetic
  - All operations are modulo 2^WIDTH.
  - carry_out = final carry XOR op_sub, so subtraction reports a borrow.
  - overflow = (A_msb == B'_msb) && (R_msb != A_msb), where B' is the inverted B when subtracting.
  - zero is computed from the full WIDTH-bit final result.
- Flags hold their values between completions. result is not visible until DONE, because partial slices build in an internal shadow register.
- op_acc=1 with no prior operation uses result=0.

Test Plan:
- WIDTH=8, DIGIT=1: start with a=8'h3C, b=8'h05, op_sub=0 → after 9 edges, done pulses one cycle; result=8'h41, carry_out=0, overflow=0, zero=0; busy high for exactly 8 cycles.
- WIDTH=8, DIGIT=1: a=8'h05, b=8'h07, op_sub=1 → result=8'hFE, carry_out=1 (borrow), overflow=0. Then a=8'h80, b=8'h01, op_sub=1 → result=8'h7F, overflow=1, carry_out=0.
- WIDTH=8, DIGIT=4: a=8'hFF, b=8'h01, op_sub=0 → done 3 edges after start; result=8'h00, carry_out=1, zero=1, overflow=0.
- Accumulate, WIDTH=8, DIGIT=2: after reset, issue three starts with op_acc=1, op_sub=0, b=8'h10 → results 8'h10, 8'h20, 8'h30. Then op_sub=1, b=8'h40 → result=8'hF0, carry_out=1.
- Handshake: pulse start again on every cycle of BUSY with different a/b → ignored; result matches the first latched operands. start held high continuously → operations complete every WIDTH/DIGIT+2 cycles.
- Reset mid-operation: assert rst_n=0 during the 4th BUSY cycle → next cycle busy=0, done=0, result=0, zero=1; no done pulse follows. A subsequent start completes normally.

Source files
------------

// File: rtl/add_sub_serial.sv
// Digit-serial add/subtract unit: processes DIGIT bits per clock, LSB slice first,
// with start/busy/done handshake and carry/borrow, overflow and zero flags.
module add_sub_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic             op_acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NSLICE = WIDTH / DIGIT;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH < 2) || (DIGIT == 0) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("add_sub_serial: WIDTH must be >= 2 and an integer multiple of DIGIT");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_sub;
  logic             r_carry;
  logic             r_a_msb;
  logic             r_bx_msb;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_zero;

  logic [DIGIT-1:0] w_bx;
  logic [DIGIT:0]   w_ext;
  logic [DIGIT-1:0] w_slice;
  logic             w_cout;
  logic [WIDTH-1:0] w_sum_nxt;
  logic [WIDTH-1:0] w_a_sel;
  logic             w_last;

  // One slice of the ripple: B is inverted and carry-in preloaded with op_sub for subtraction
  assign w_bx      = r_b[DIGIT-1:0] ^ {DIGIT{r_sub}};
  assign w_ext     = (DIGIT+1)'(r_a[DIGIT-1:0]) + (DIGIT+1)'(w_bx) + (DIGIT+1)'(r_carry);
  assign w_slice   = w_ext[DIGIT-1:0];
  assign w_cout    = w_ext[DIGIT];
  assign w_sum_nxt = WIDTH'({w_slice, r_sum} >> DIGIT);
  assign w_a_sel   = op_acc ? r_result : a;
  assign w_last    = (r_cnt == CW'(NSLICE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand shifters, shadow sum and flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_sub       <= 1'b0;
      r_carry     <= 1'b0;
      r_a_msb     <= 1'b0;
      r_bx_msb    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b1;
    end else begin
      r_busy <= (w_state_nxt == S_BUSY);
      r_done <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= w_a_sel;
            r_b      <= b;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_sub    <= op_sub;
            r_carry  <= op_sub;
            r_a_msb  <= w_a_sel[WIDTH-1];
            r_bx_msb <= b[WIDTH-1] ^ op_sub;
          end
        end
        S_BUSY: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_sum   <= w_sum_nxt;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_result    <= w_sum_nxt;
            r_carry_out <= w_cout ^ r_sub;
            r_overflow  <= (r_a_msb == r_bx_msb) && (w_slice[DIGIT-1] != r_a_msb);
            r_zero      <= (w_sum_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule

// File: tb/tb_add_sub_serial.sv
// Scoreboard bench for add_sub_serial: three WIDTH=8 instances with DIGIT = 1, 4, 2.
module tb_add_sub_serial;

  localparam int NI = 3;

  typedef struct {
    int         inst;
    logic [7:0] r;
    logic       c;
    logic       v;
    logic       z;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start    [NI];
  logic       op_sub   [NI];
  logic       op_acc   [NI];
  logic [7:0] a        [NI];
  logic [7:0] b        [NI];
  logic       busy     [NI];
  logic       done     [NI];
  logic [7:0] result   [NI];
  logic       carry_out[NI];
  logic       overflow [NI];
  logic       zero     [NI];

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic int dig(input int g);
    return (g == 1) ? 4 : (g == 2) ? 2 : 1;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    add_sub_serial #(.WIDTH(8), .DIGIT((g == 1) ? 4 : (g == 2) ? 2 : 1)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .op_sub(op_sub[g]), .op_acc(op_acc[g]),
      .a(a[g]), .b(b[g]), .busy(busy[g]), .done(done[g]), .result(result[g]),
      .carry_out(carry_out[g]), .overflow(overflow[g]), .zero(zero[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop and compare whenever an instance pulses done
  for (genvar g = 0; g < NI; g++) begin : g_mon
    always @(negedge clk) begin
      exp_t e;
      if (done[g] === 1'b1) begin
        if (sbq.size() == 0) begin
          chk($sformatf("unexpected_done_i%0d", g), 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("sb_inst", g, e.inst);
          chk($sformatf("result_i%0d", g), int'(result[g]), int'(e.r));
          chk($sformatf("carry_i%0d", g), int'(carry_out[g]), int'(e.c));
          chk($sformatf("overflow_i%0d", g), int'(overflow[g]), int'(e.v));
          chk($sformatf("zero_i%0d", g), int'(zero[g]), int'(e.z));
          chk($sformatf("busy_in_done_i%0d", g), int'(busy[g]), 0);
        end
      end
    end
  end

  // Issue one operation; pulse=1 keeps re-asserting start with junk operands while busy
  task automatic do_op(input int g, input logic sub, input logic acc, input logic [7:0] av,
                       input logic [7:0] bv, input logic [7:0] er, input logic ec,
                       input logic ev, input logic ez, input bit pulse);
    int k;
    int nb;
    int ns;
    exp_t e;
    ns = 8 / dig(g);
    e.inst = g; e.r = er; e.c = ec; e.v = ev; e.z = ez;
    sbq.push_back(e);
    @(negedge clk);
    a[g] = av; b[g] = bv; op_sub[g] = sub; op_acc[g] = acc; start[g] = 1'b1;
    k = 0;
    nb = 0;
    do begin
      @(negedge clk);
      k++;
      if (busy[g] === 1'b1) nb++;
      if (pulse && busy[g] === 1'b1) begin
        start[g] = 1'b1;
        a[g] = 8'($urandom);
        b[g] = 8'($urandom);
        op_sub[g] = ~sub;
        op_acc[g] = ~acc;
      end else begin
        start[g] = 1'b0;
      end
    end while (done[g] !== 1'b1 && k < 40);
    start[g] = 1'b0;
    chk($sformatf("latency_i%0d", g), k, ns + 1);
    chk($sformatf("busy_cycles_i%0d", g), nb, ns);
    @(negedge clk);
    chk($sformatf("done_width_i%0d", g), int'(done[g]), 0);
  endtask

  initial begin
    int k;
    int k1;
    exp_t e;
    rst_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      start[g] = 1'b0; op_sub[g] = 1'b0; op_acc[g] = 1'b0; a[g] = '0; b[g] = '0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("rst_busy", int'(busy[g]), 0);
      chk("rst_done", int'(done[g]), 0);
      chk("rst_result", int'(result[g]), 0);
      chk("rst_carry", int'(carry_out[g]), 0);
      chk("rst_overflow", int'(overflow[g]), 0);
      chk("rst_zero", int'(zero[g]), 1);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add/sub on DIGIT=1
    do_op(0, 1'b0, 1'b0, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(0, 1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(0, 1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
    // Wrap to zero on DIGIT=4
    do_op(1, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    // Accumulate chain on DIGIT=2; input a is junk and must be ignored
    do_op(2, 1'b0, 1'b1, 8'hAA, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(2, 1'b0, 1'b1, 8'h55, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(2, 1'b0, 1'b1, 8'hC3, 8'h10, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(2, 1'b1, 1'b1, 8'h01, 8'h40, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
    // start re-pulsed throughout BUSY with changing operands
    do_op(0, 1'b0, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1'b1);

    // start held high: back-to-back completions every WIDTH/DIGIT+2 cycles
    e.inst = 0; e.r = 8'h41; e.c = 1'b0; e.v = 1'b0; e.z = 1'b0;
    sbq.push_back(e);
    sbq.push_back(e);
    @(negedge clk);
    a[0] = 8'h3C; b[0] = 8'h05; op_sub[0] = 1'b0; op_acc[0] = 1'b0; start[0] = 1'b1;
    k = 0;
    k1 = -1;
    do begin
      @(negedge clk);
      k++;
      if (done[0] === 1'b1 && k1 < 0) begin
        k1 = k;
      end else if (done[0] === 1'b1) begin
        start[0] = 1'b0;
      end
    end while (!(done[0] === 1'b1 && k1 != k) && k < 60);
    start[0] = 1'b0;
    chk("b2b_first_latency", k1, 9);
    chk("b2b_spacing", k - k1, 10);
    repeat (3) @(negedge clk);

    // Reset during the 4th BUSY cycle aborts with no done pulse
    @(negedge clk);
    a[0] = 8'h11; b[0] = 8'h22; op_sub[0] = 1'b0; start[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    chk("busy_before_abort", int'(busy[0]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_done", int'(done[0]), 0);
    chk("abort_result", int'(result[0]), 0);
    chk("abort_zero", int'(zero[0]), 1);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    do_op(0, 1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
